// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MIPS pipeline-register slice: control-bundle
//   bit positions, the bubble encoding and the drain FSM state type.
package mips_pkg;

  localparam int CTRL_W = 10;

  // Ctrl bundle = {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, Branch, ALUControl[3:0]}
  localparam int CTRL_REGWRITE    = 9;
  localparam int CTRL_MEMTOREG    = 8;
  localparam int CTRL_MEMWRITE    = 7;
  localparam int CTRL_ALUSRC      = 6;
  localparam int CTRL_REGDST      = 5;
  localparam int CTRL_BRANCH      = 4;
  localparam int CTRL_ALUCTRL_LSB = 0;
  localparam int CTRL_ALUCTRL_W   = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    DS_RUN    = 2'd0,
    DS_DRAIN  = 2'd1,
    DS_HALTED = 2'd2
  } drain_state_t;

endpackage

// File: rtl/pipe_stage_regs_sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk, rst  : clock, async active-high reset (clears to 0)
//   inc       : count this cycle
//   freeze    : hold the current value regardless of inc
//   count     : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         freeze,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !freeze && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs
//   IF/ID and ID/EX pipeline registers for the five-stage MIPS core, with
//   hazard stall/flush handling, per-stage valid bits, end-of-program drain
//   sequencing and saturating stall/flush performance counters.
//
//   CLK, reset            : clock, async active-high reset
//   Instr_F, PCPlus4_F    : fetch-stage instruction and PC+4
//   Stall_F/Stall_D       : hazard stalls (PC, IF/ID)
//   Flush_D/Flush_E       : hazard flushes (IF/ID, ID/EX)
//   Ctrl_D, RD1_D, RD2_D,
//   SignImm_D             : decode-stage control bundle and operands
//   PC_En_F               : PC register enable (combinational)
//   Instr_D, PCPlus4_D    : IF/ID contents, plus decoded field slices
//   Valid_D, Valid_E      : stage holds a real instruction
//   Ctrl_E ... Rd_E       : ID/EX contents
//   Halted                : drain after the halt instruction is complete
//   Stall_Cnt, Flush_Cnt  : saturating performance counters
//
//   Drain FSM
//   state     | meaning
//   ----------+---------------------------------------------------------
//   DS_RUN    | normal operation, fetch enabled
//   DS_DRAIN  | halt seen in decode; fetch off, bubbles fed, counting down
//   DS_HALTED | pipeline empty; absorbing until reset
module pipe_stage_regs
  import mips_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int          CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [31:0]       Instr_F,
  input  logic [31:0]       PCPlus4_F,
  input  logic              Stall_F,
  input  logic              Stall_D,
  input  logic              Flush_D,
  input  logic              Flush_E,
  input  logic [CTRL_W-1:0] Ctrl_D,
  input  logic [31:0]       RD1_D,
  input  logic [31:0]       RD2_D,
  input  logic [31:0]       SignImm_D,
  output logic              PC_En_F,
  output logic [31:0]       Instr_D,
  output logic [31:0]       PCPlus4_D,
  output logic [5:0]        Opcode_D,
  output logic [5:0]        Funct_D,
  output logic [4:0]        Rs_D,
  output logic [4:0]        Rt_D,
  output logic [4:0]        Rd_D,
  output logic              Valid_D,
  output logic              Valid_E,
  output logic [CTRL_W-1:0] Ctrl_E,
  output logic [31:0]       RD1_E,
  output logic [31:0]       RD2_E,
  output logic [31:0]       SignImm_E,
  output logic [4:0]        Rs_E,
  output logic [4:0]        Rt_E,
  output logic [4:0]        Rd_E,
  output logic              Halted,
  output logic [CNT_W-1:0]  Stall_Cnt,
  output logic [CNT_W-1:0]  Flush_Cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  drain_state_t        drainState;
  logic [DRAIN_W-1:0]  drainCnt;
  logic                inRun;
  logic                haltInDecode;

  assign inRun = (drainState == DS_RUN);

  assign Opcode_D = Instr_D[31:26];
  assign Rs_D     = Instr_D[25:21];
  assign Rt_D     = Instr_D[20:16];
  assign Rd_D     = Instr_D[15:11];
  assign Funct_D  = Instr_D[5:0];

  assign PC_En_F = ~Stall_F & inRun;
  assign Halted  = (drainState == DS_HALTED);

  // A halt that is being stalled or flushed this cycle is not committed yet.
  assign haltInDecode = Valid_D && (Instr_D == HALT_INSTR) && !Stall_D && !Flush_D;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      drainState <= DS_RUN;
      drainCnt   <= '0;
    end else begin
      case (drainState)
        DS_RUN: begin
          if (haltInDecode) begin
            drainState <= DS_DRAIN;
            drainCnt   <= DRAIN_W'(DRAIN_CYCLES - 1);
          end
        end
        DS_DRAIN: begin
          if (drainCnt == '0) begin
            drainState <= DS_HALTED;
          end else begin
            drainCnt <= drainCnt - DRAIN_W'(1);
          end
        end
        DS_HALTED: drainState <= DS_HALTED;
        default: begin
          drainState <= DS_RUN;
          drainCnt   <= '0;
        end
      endcase
    end
  end

  // IF/ID: flush beats stall; outside RUN only bubbles enter decode.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      Instr_D   <= NOP_INSTR;
      PCPlus4_D <= '0;
      Valid_D   <= 1'b0;
    end else if (Flush_D) begin
      Instr_D   <= NOP_INSTR;
      PCPlus4_D <= '0;
      Valid_D   <= 1'b0;
    end else if (!Stall_D) begin
      if (!inRun) begin
        Instr_D   <= NOP_INSTR;
        PCPlus4_D <= '0;
        Valid_D   <= 1'b0;
      end else begin
        Instr_D   <= Instr_F;
        PCPlus4_D <= PCPlus4_F;
        Valid_D   <= 1'b1;
      end
    end
  end

  // ID/EX is never held. The control bundle of an invalid decode slot is
  // zeroed so an EX bubble can never look like a register writer or a load.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      Ctrl_E    <= '0;
      RD1_E     <= '0;
      RD2_E     <= '0;
      SignImm_E <= '0;
      Rs_E      <= '0;
      Rt_E      <= '0;
      Rd_E      <= '0;
      Valid_E   <= 1'b0;
    end else if (Flush_E) begin
      Ctrl_E    <= '0;
      RD1_E     <= '0;
      RD2_E     <= '0;
      SignImm_E <= '0;
      Rs_E      <= '0;
      Rt_E      <= '0;
      Rd_E      <= '0;
      Valid_E   <= 1'b0;
    end else begin
      Ctrl_E    <= Valid_D ? Ctrl_D : '0;
      RD1_E     <= RD1_D;
      RD2_E     <= RD2_D;
      SignImm_E <= SignImm_D;
      Rs_E      <= Rs_D;
      Rt_E      <= Rt_D;
      Rd_E      <= Rd_D;
      Valid_E   <= Valid_D;
    end
  end

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk    (CLK),
    .rst    (reset),
    .inc    (Stall_D & inRun),
    .freeze (Halted),
    .count  (Stall_Cnt)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .clk    (CLK),
    .rst    (reset),
    .inc    (Flush_D),
    .freeze (Halted),
    .count  (Flush_Cnt)
  );

endmodule
